// File: rtl/lut_neuron_table_loader_if.sv
// Configuration stream and evaluation port of the run-time writable LUT neuron.
// The master side is the config/readback controller plus the layer slot; the
// slave side is the table loader itself.
interface lut_neuron_table_loader_if #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 2
);
  // Table load stream
  logic                cfg_start;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [OUT_BITS-1:0] cfg_data;
  logic                cfg_last;
  // Load status
  logic                table_valid;
  logic                load_error;
  // Evaluation
  logic                eval_valid;
  logic [IN_BITS-1:0]  eval_in;
  logic                eval_out_valid;
  logic [OUT_BITS-1:0] eval_out;

  modport master (
    output cfg_start, cfg_valid, cfg_data, cfg_last, eval_valid, eval_in,
    input  cfg_ready, table_valid, load_error, eval_out_valid, eval_out
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_data, cfg_last, eval_valid, eval_in,
    output cfg_ready, table_valid, load_error, eval_out_valid, eval_out
  );
endinterface

// File: rtl/lut_neuron_table_loader.sv
// Run-time writable LUT neuron: one 2^IN_BITS x OUT_BITS truth table in
// distributed RAM, filled by an in-order valid/ready stream and then looked up
// with a one-cycle registered read, exactly like a generated neuron ROM.
module lut_neuron_table_loader #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  lut_neuron_table_loader_if.slave     bus
);

  localparam int                 DEPTH     = 1 << IN_BITS;
  localparam logic [IN_BITS-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_LOAD,
    S_READY,
    S_ERROR
  } state_e;

  state_e              state_q, state_d;
  logic [IN_BITS-1:0]  addr_q, addr_d;
  logic                load_error_q, load_error_d;
  logic                wr_en;
  logic [IN_BITS-1:0]  wr_addr;
  logic                eval_accept;
  logic                eval_out_valid_q;
  logic [OUT_BITS-1:0] eval_out_q;
  logic [OUT_BITS-1:0] mem [DEPTH];

  // Control state, load address and sticky error flag.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering in the simulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_EMPTY;
      addr_q       <= '0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      load_error_q <= load_error_d;
    end
  end

  // Next-state, address and write-enable decode.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    load_error_d = load_error_q;
    wr_en        = 1'b0;
    wr_addr      = addr_q;

    unique case (state_q)
      S_EMPTY, S_READY, S_ERROR: begin
        if (bus.cfg_start) begin
          state_d      = S_LOAD;
          addr_d       = '0;
          load_error_d = 1'b0;
        end
      end
      S_LOAD: begin
        // A restart discards progress; an entry arriving with it lands at 0.
        if (bus.cfg_start) begin
          wr_addr = '0;
          addr_d  = '0;
        end
        if (bus.cfg_valid) begin
          wr_en  = 1'b1;
          addr_d = wr_addr + IN_BITS'(1);
          if (wr_addr == LAST_ADDR) begin
            // Final slot: only a correctly flagged last entry completes the load.
            if (bus.cfg_last) begin
              state_d = S_READY;
            end else begin
              state_d      = S_ERROR;
              load_error_d = 1'b1;
            end
          end else if (bus.cfg_last) begin
            state_d      = S_ERROR;
            load_error_d = 1'b1;
          end
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Table storage, written only while loading.
  // NOTE: the RAM has no reset; a partial table is never exposed because
  // lookups are only honoured in READY, which requires a complete load.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= bus.cfg_data;
    end
  end

  assign eval_accept = bus.eval_valid && (state_q == S_READY);

  // Registered lookup; the result holds when a lookup is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eval_out_valid_q <= 1'b0;
      eval_out_q       <= '0;
    end else begin
      eval_out_valid_q <= eval_accept;
      if (eval_accept) begin
        eval_out_q <= mem[bus.eval_in];
      end
    end
  end

  assign bus.cfg_ready      = (state_q == S_LOAD);
  assign bus.table_valid    = (state_q == S_READY);
  assign bus.load_error     = load_error_q;
  assign bus.eval_out_valid = eval_out_valid_q;
  assign bus.eval_out       = eval_out_q;

endmodule

// File: tb/tb_lut_neuron_table_loader.sv
// Bench for lut_neuron_table_loader: a load-level reference model decides
// whether each table load succeeds and which table is live; expected lookup
// results go into a queue that a separate monitor drains on eval_out_valid.
module tb_lut_neuron_table_loader;

  localparam int ST_LOADING = 0;
  localparam int ST_READY   = 1;
  localparam int ST_ERROR   = 2;

  logic clk;
  logic rst_n;

  lut_neuron_table_loader_if #(.IN_BITS(8), .OUT_BITS(2)) bus_if ();

  lut_neuron_table_loader #(.IN_BITS(8), .OUT_BITS(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [1:0] stim_tbl  [256];
  logic [1:0] model_tbl [256];
  bit         m_ready = 1'b0;
  logic [1:0] m_last  = 2'd0;
  logic [1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Generated neuron ROM used as a known reference table.
  function automatic logic [1:0] rom(input logic [7:0] x);
    case (x)
      8'hF0:   rom = 2'b10;
      8'hFF:   rom = 2'b01;
      8'h80:   rom = 2'b01;
      default: rom = {^x[7:4], x[0] & ~x[5]};
    endcase
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented result must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus_if.eval_out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_eval_out_valid", 32'(1), 32'(0));
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        check("eval_out", 32'(bus_if.eval_out), 32'(e));
      end
    end
  end

  task automatic eval_one(input logic [7:0] idx);
    bus_if.eval_valid = 1'b1;
    bus_if.eval_in    = idx;
    if (m_ready) begin
      exp_q.push_back(model_tbl[idx]);
      m_last = model_tbl[idx];
    end
    step;
    bus_if.eval_valid = 1'b0;
  endtask

  task automatic eval_seq(input int n, input bit sweep, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) while ($urandom_range(0, 3) == 0) begin
        bus_if.eval_in = 8'($urandom);
        step;
      end
      eval_one(sweep ? 8'(i) : 8'($urandom));
    end
  endtask

  task automatic reset_now;
    #2 rst_n = 1'b0;
    #1;
    check("rst_cfg_ready", 32'(bus_if.cfg_ready), 32'(0));
    check("rst_table_valid", 32'(bus_if.table_valid), 32'(0));
    check("rst_load_error", 32'(bus_if.load_error), 32'(0));
    check("rst_eval_out_valid", 32'(bus_if.eval_out_valid), 32'(0));
    check("rst_eval_out", 32'(bus_if.eval_out), 32'(0));
    m_ready = 1'b0;
    m_last  = 2'd0;
    bus_if.cfg_valid = 1'b0;
    bus_if.cfg_last  = 1'b0;
    step;
    rst_n = 1'b1;
    step;
  endtask

  // Stream stim_tbl[0..n_send-1]; cfg_last on entry last_at (-1: never).
  task automatic do_load(input bit start_data, input int n_send, input int last_at,
                         input bit gaps, input int rst_entry);
    int i0;
    int status;
    bit aborted;
    aborted = 1'b0;
    bus_if.cfg_start = 1'b1;
    if (start_data) begin
      bus_if.cfg_valid = 1'b1;
      bus_if.cfg_data  = stim_tbl[0];
      bus_if.cfg_last  = (last_at == 0);
      i0 = 1;
    end else begin
      i0 = 0;
    end
    step;
    m_ready = 1'b0;
    bus_if.cfg_start = 1'b0;
    bus_if.cfg_valid = 1'b0;
    bus_if.cfg_last  = 1'b0;
    @(negedge clk);
    check("cfg_ready_in_load", 32'(bus_if.cfg_ready), 32'(1));
    step;
    for (int i = i0; i < n_send; i++) begin
      if (gaps) while ($urandom_range(0, 2) == 0) begin
        bus_if.cfg_valid = 1'b0;
        bus_if.cfg_data  = 2'($urandom);
        bus_if.cfg_last  = 1'($urandom);
        step;
      end
      if (i == rst_entry) begin
        reset_now();
        aborted = 1'b1;
        break;
      end
      bus_if.cfg_valid = 1'b1;
      bus_if.cfg_data  = stim_tbl[i];
      bus_if.cfg_last  = (i == last_at);
      step;
    end
    bus_if.cfg_valid = 1'b0;
    bus_if.cfg_last  = 1'b0;
    if (!aborted) begin
      if (last_at >= 0 && last_at < n_send) status = (last_at == 255) ? ST_READY : ST_ERROR;
      else if (n_send >= 256)              status = ST_ERROR;
      else                                 status = ST_LOADING;
      m_ready = (status == ST_READY);
      if (m_ready) model_tbl = stim_tbl;
      @(negedge clk);
      check("table_valid_after_load", 32'(bus_if.table_valid), 32'(status == ST_READY));
      check("load_error_after_load", 32'(bus_if.load_error), 32'(status == ST_ERROR));
      step;
    end
  endtask

  task automatic fill_random;
    for (int i = 0; i < 256; i++) stim_tbl[i] = 2'($urandom);
  endtask

  task automatic fill_rom;
    for (int i = 0; i < 256; i++) stim_tbl[i] = rom(8'(i));
  endtask

  task automatic check_dropped(input string name);
    @(negedge clk);
    check({name, "_valid"}, 32'(bus_if.eval_out_valid), 32'(0));
    check({name, "_hold"}, 32'(bus_if.eval_out), 32'(m_last));
    step;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus_if.cfg_start  = 1'b0;
    bus_if.cfg_valid  = 1'b0;
    bus_if.cfg_data   = 2'd0;
    bus_if.cfg_last   = 1'b0;
    bus_if.eval_valid = 1'b0;
    bus_if.eval_in    = 8'd0;
    #10;
    check("init_cfg_ready", 32'(bus_if.cfg_ready), 32'(0));
    check("init_table_valid", 32'(bus_if.table_valid), 32'(0));
    check("init_load_error", 32'(bus_if.load_error), 32'(0));
    check("init_eval_out_valid", 32'(bus_if.eval_out_valid), 32'(0));
    check("init_eval_out", 32'(bus_if.eval_out), 32'(0));
    #2 rst_n = 1'b1;
    step;

    // Evaluation before any load is dropped.
    eval_seq(3, 1'b0, 1'b0);
    check_dropped("empty_eval");

    // table[i] = i[1:0], then four back-to-back lookups.
    for (int i = 0; i < 256; i++) stim_tbl[i] = 2'(i);
    do_load(1'b0, 256, 255, 1'b0, -1);
    eval_one(8'h00);
    eval_one(8'hF0);
    eval_one(8'hFF);
    eval_one(8'h03);

    // Random table with stream gaps, random lookups with gaps.
    fill_random();
    do_load(1'b0, 256, 255, 1'b1, -1);
    eval_seq(40, 1'b0, 1'b1);

    // Generated neuron ROM, gap-free, exhaustive sweep.
    fill_rom();
    do_load(1'b0, 256, 255, 1'b0, -1);
    eval_seq(256, 1'b1, 1'b0);

    // Early cfg_last -> error; lookups are dropped and the output holds.
    fill_random();
    do_load(1'b0, 101, 100, 1'b0, -1);
    eval_seq(5, 1'b0, 1'b1);
    check_dropped("error_eval");

    // Recover with the ROM loaded through a gappy stream.
    fill_rom();
    do_load(1'b0, 256, 255, 1'b1, -1);
    eval_seq(256, 1'b1, 1'b1);

    // Missing cfg_last on the final entry -> error.
    fill_random();
    do_load(1'b0, 256, -1, 1'b0, -1);
    eval_seq(4, 1'b0, 1'b0);
    check_dropped("nolast_eval");

    // Partial load, then a restart whose start cycle carries entry 0.
    fill_random();
    do_load(1'b0, 50, -1, 1'b0, -1);
    fill_random();
    do_load(1'b1, 256, 255, 1'b0, -1);
    eval_seq(30, 1'b0, 1'b0);
    eval_one(8'h00);

    // cfg_start in READY with a same-cycle lookup: that lookup completes.
    bus_if.cfg_start  = 1'b1;
    bus_if.eval_valid = 1'b1;
    bus_if.eval_in    = 8'h00;
    exp_q.push_back(model_tbl[8'h00]);
    m_last = model_tbl[8'h00];
    step;
    bus_if.cfg_start  = 1'b0;
    bus_if.eval_valid = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    check("table_valid_drop_on_start", 32'(bus_if.table_valid), 32'(0));
    step;
    eval_seq(4, 1'b0, 1'b0);
    check_dropped("reload_eval");
    fill_rom();
    do_load(1'b0, 256, 255, 1'b0, -1);
    eval_seq(8, 1'b0, 1'b0);
    eval_one(8'hFF);

    // Reset during entry 130 of a load; lookups afterwards are dropped.
    fill_random();
    do_load(1'b0, 256, 255, 1'b1, 130);
    eval_seq(5, 1'b0, 1'b0);
    check_dropped("post_reset_eval");
    check("post_reset_table_valid", 32'(bus_if.table_valid), 32'(0));

    // Final good load.
    fill_random();
    do_load(1'b0, 256, 255, 1'b1, -1);
    eval_seq(30, 1'b0, 1'b1);

    repeat (4) step;
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lut_neuron_table_loader.md
Name: lut_neuron_table_loader

Overview:
- Run-time writable counterpart of the fixed LUT neurons: one 2^IN_BITS x OUT_BITS truth table held in distributed RAM.
- Loaded by a sequential valid/ready stream from the configuration path, then evaluated exactly like a generated neuron (input word indexes the table).
- Sits between the config/readback controller and a layer slot. Lets the team swap neuron tables without re-synthesis, and lets the bench read a table back against the generated ROMs.

Parameters:
- IN_BITS, 8, table address width (concatenated neuron input word).
- OUT_BITS, 2, width of each table entry (neuron output).

Ports:
- clk  input  1  single clock, all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- cfg_start  input  1  one-cycle pulse: begin a new table load.
- cfg_valid  input  1  cfg_data holds an entry.
- cfg_ready  output  1  block accepts entry this cycle.
- cfg_data  input  OUT_BITS  table entry for the current load address.
- cfg_last  input  1  marks the final entry of the load.
- table_valid  output  1  table fully and correctly loaded.
- load_error  output  1  sticky: last load was malformed.
- eval_valid  input  1  eval_in is valid.
- eval_in  input  IN_BITS  neuron input word (table index).
- eval_out_valid  output  1  eval_out is valid.
- eval_out  output  OUT_BITS  table[eval_in], registered.

Behaviour:
- Reset (async assert, sync release): state EMPTY; cfg_ready=0, table_valid=0, load_error=0, eval_out_valid=0, eval_out=0, load address counter=0. RAM contents are not reset.
- States:
  - EMPTY: cfg_start -> LOAD, clears load_error and address counter.
  - LOAD: cfg_ready=1. Each cfg_valid&&cfg_ready writes cfg_data to RAM[addr] and increments addr. Entry order is index order 0..2^IN_BITS-1, matching the bit layout of the generated neuron's input word.
  - LOAD ends when an entry is accepted:
    - cfg_last=1 at addr=2^IN_BITS-1 -> READY, table_valid=1.
    - cfg_last=1 at any other addr -> ERROR, load_error=1.
    - cfg_last=0 at addr=2^IN_BITS-1 -> ERROR; the entry is still written and addr wraps to 0.
  - READY: table_valid=1, cfg_ready=0. cfg_start -> LOAD; table_valid drops the next cycle.
  - ERROR: table_valid=0, cfg_ready=0, load_error held. Only cfg_start (-> LOAD) or reset leaves ERROR.
- cfg_start while in LOAD: restarts the load at addr 0 and discards progress. If cfg_valid is also high that cycle, that entry is written to addr 0.
- cfg_valid with cfg_ready=0: ignored, no write.
- Evaluation:
  - Latency 1 cycle. In READY, eval_valid at cycle N gives eval_out_valid=1 and eval_out=RAM[eval_in] at N+1.
  - Fully pipelined: one lookup per cycle, no backpressure.
  - Outside READY, eval_valid is dropped: eval_out_valid=0 next cycle and eval_out holds its last value.
- Read/write overlap cannot occur: writes happen only in LOAD, reads only in READY.
- Reset mid-load: returns to EMPTY, table_valid=0. A partially written table is never exposed.

Test Plan:
- Reset, then load 256 entries with table[i]=i[1:0] and cfg_last on entry 255 -> table_valid=1 the cycle after the last accept, load_error=0. Then eval 8'h00, 8'hF0, 8'hFF, 8'h03 back-to-back -> eval_out 0,0,3,3 on consecutive cycles, eval_out_valid high for 4 cycles.
- Load a generated neuron's table (e.g. entry[8'hF0]=2'b10, entry[8'hFF]=2'b01, entry[8'h80]=2'b01, rest per that ROM) -> exhaustive sweep of all 256 eval_in values matches the combinational ROM model exactly.
- Assert cfg_last on entry 100 -> load_error=1, table_valid=0. Subsequent eval_valid pulses -> eval_out_valid stays 0. cfg_start plus a correct load -> load_error clears, table_valid=1.
- cfg_valid toggled randomly with gaps during LOAD -> exactly 256 writes, same results as the gap-free load.
- Assert rst_n low at entry 130 of a load -> all outputs 0 asynchronously, state EMPTY. eval_valid after reset -> no eval_out_valid.
- In READY, pulse cfg_start with eval_valid in the same cycle -> that lookup completes (eval_out_valid=1 next cycle). table_valid=0 from the next cycle; later evals are dropped until the reload completes.
